// File: rtl/serial_sub.sv
// serial_sub: bit-serial LSB-first unsigned subtractor (diff = a - b) with start/busy/done handshake
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, done_q, done_d, borrow_q, borrow_d, a0, b0, last;
  always_comb begin
    a0 = sa_q[0];
    b0 = sb_q[0];
    last = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    sa_d = sa_q;
    sb_d = sb_q;
    diff_d = diff_q;
    cnt_d = cnt_q;
    br_d = br_q;
    borrow_d = borrow_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        sa_d = a;
        sb_d = b;
        br_d = 1'b0;
        cnt_d = '0;
      end
    end else begin
      // new result bit enters at the MSB so the LSB-first stream lands in place
      diff_d = WIDTH'({a0 ^ b0 ^ br_q, diff_q} >> 1);
      br_d = (~a0 & b0) | (~(a0 ^ b0) & br_q);
      sa_d = sa_q >> 1;
      sb_d = sb_q >> 1;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        borrow_d = br_d;
        done_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q <= '0;
      sb_q <= '0;
      diff_q <= '0;
      cnt_q <= '0;
      br_q <= 1'b0;
      borrow_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      diff_q <= diff_d;
      cnt_q <= cnt_d;
      br_q <= br_d;
      borrow_q <= borrow_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = done_q;
  assign diff = diff_q;
  assign borrow = borrow_q;
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: random and directed scoreboard bench for serial_sub at WIDTH=8 and WIDTH=1
module tb_serial_sub;
  typedef struct {logic [7:0] d; logic br; int t;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic st8 = 1'b0, st1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic [0:0] a1 = '0, b1 = '0, diff1;
  logic busy8, done8, brw8, busy1, done1, brw1;
  int cyc = 0, errors = 0, checks = 0;
  exp_t q8[$], q1[$];

  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .reset(rst), .start(st8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(brw8));
  serial_sub #(.WIDTH(1)) dut1 (.clk(clk), .reset(rst), .start(st1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(brw1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endfunction

  function automatic void miss(string n);
    checks++;
    errors++;
    $display("FAIL %s @cyc %0d", n, cyc);
  endfunction

  // monitors: sample after the edge has settled, compare against the queued expectation
  always @(posedge clk) begin
    #1;
    chk("busy8", busy8, q8.size() > 0 && cyc < q8[0].t);
    if (q8.size() > 0 && cyc > q8[0].t) begin
      miss("done8_missing");
      void'(q8.pop_front());
    end
    if (done8) begin
      if (q8.size() == 0) miss("done8_unexpected");
      else begin
        chk("done8_latency", cyc, q8[0].t);
        chk("diff8", diff8, q8[0].d);
        chk("borrow8", brw8, q8[0].br);
        void'(q8.pop_front());
      end
    end
    chk("busy1", busy1, q1.size() > 0 && cyc < q1[0].t);
    if (q1.size() > 0 && cyc > q1[0].t) begin
      miss("done1_missing");
      void'(q1.pop_front());
    end
    if (done1) begin
      if (q1.size() == 0) miss("done1_unexpected");
      else begin
        chk("done1_latency", cyc, q1[0].t);
        chk("diff1", diff1, q1[0].d);
        chk("borrow1", brw1, q1[0].br);
        void'(q1.pop_front());
      end
    end
  end

  // caller sits at a negedge where dut8 is idle or pulsing done
  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.d = a - b;
    e.br = a < b;
    e.t = cyc + 1 + 8;
    a8 = a;
    b8 = b;
    st8 = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    st8 = 1'b0;
    a8 = $urandom;
    b8 = $urandom;
  endtask

  task automatic poke8();
    a8 = $urandom;
    b8 = $urandom;
    st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
  endtask

  task automatic wait_done8();
    for (int i = 0; i < 30; i++) begin
      if (done8) break;
      @(negedge clk);
    end
    if (!done8) miss("done8_timeout");
  endtask

  task automatic launch1(input logic a, input logic b);
    exp_t e;
    e.d = {7'd0, a ^ b};
    e.br = ~a & b;
    e.t = cyc + 2;
    a1 = a;
    b1 = b;
    st1 = 1'b1;
    q1.push_back(e);
    @(negedge clk);
    st1 = 1'b0;
  endtask

  initial begin
    st8 = 1'b1;
    st1 = 1'b1;
    a8 = 8'h5A;
    b8 = 8'h3C;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_borrow", brw8, 0);
    st8 = 1'b0;
    st1 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    launch8(8'h5A, 8'h3C);
    wait_done8();
    @(negedge clk);
    launch8(8'h00, 8'h01);
    wait_done8();
    launch8(8'hFF, 8'hFF);
    wait_done8();
    @(negedge clk);
    // start during RUN must be ignored; then back-to-back in the done cycle
    launch8(8'h10, 8'h01);
    @(negedge clk);
    poke8();
    wait_done8();
    launch8(8'h80, 8'hC3);
    wait_done8();
    @(negedge clk);
    // reset mid-operation aborts without a done pulse
    launch8(8'h77, 8'h11);
    repeat (3) @(negedge clk);
    q8.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_diff", diff8, 0);
    chk("abort_borrow", brw8, 0);
    @(negedge clk);
    launch8(8'h42, 8'h24);
    wait_done8();
    @(negedge clk);
    // WIDTH=1: all four combos back-to-back, then some idle gaps
    for (int i = 0; i < 4; i++) begin
      launch1(i[1], i[0]);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      launch1(1'($urandom), 1'($urandom));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra, rb;
      ra = (n % 10 == 0) ? 8'h00 : (n % 10 == 1) ? 8'hFF : 8'($urandom);
      rb = (n % 10 == 2) ? 8'h00 : (n % 10 == 3) ? 8'hFF : 8'($urandom);
      launch8(ra, rb);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        poke8();
      end
      wait_done8();
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
